// File: rtl/awb_gain_sched_if.sv
// Divider handshake bundle between the AWB gain scheduler (master) and the
// shared external divider (slave).
interface awb_gain_sched_if;
    logic        O_div_start;
    logic [47:0] O_div_num;
    logic [31:0] O_div_den;
    logic [47:0] I_div_quot;
    logic        I_div_done;

    modport master (
        output O_div_start, O_div_num, O_div_den,
        input  I_div_quot, I_div_done
    );

    modport slave (
        input  O_div_start, O_div_num, O_div_den,
        output I_div_quot, I_div_done
    );
endinterface

// File: rtl/awb_gain_sched.sv
// Per-frame AWB gain scheduler: snapshots lane sums, runs 8 divisions on one shared
// divider into a shadow bank, and publishes it at frame start. Optional macro AWB_GAIN_CLAMP_EN.
module awb_gain_sched #(
    parameter int          LANES       = 4,
    parameter int          DIV_TIMEOUT = 128,
    parameter logic [19:0] GAIN_MIN    = 20'h04000,
    parameter logic [19:0] GAIN_MAX    = 20'h40000
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic                  I_tuser,
    input  logic                  I_frame_end,
    input  logic [32*LANES-1:0]   I_sum_r,
    input  logic [32*LANES-1:0]   I_sum_g,
    input  logic [32*LANES-1:0]   I_sum_b,
    awb_gain_sched_if.master      div,
    output logic [20*LANES-1:0]   O_gain_r,
    output logic [20*LANES-1:0]   O_gain_b,
    output logic                  O_gain_upd,
    output logic                  O_busy,
    output logic                  O_overrun,
    output logic                  O_timeout
);
    localparam int SW = 32 * LANES;
    localparam int GW = 20 * LANES;
`ifdef AWB_GAIN_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_STORE, S_PEND} state_t;

    state_t       state_q, state_d;
    logic [2:0]   job_q, job_d;
    logic [SW-1:0] snap_r_q, snap_r_d, snap_g_q, snap_g_d, snap_b_q, snap_b_d;
    logic [47:0]  num_q, num_d, quot_q, quot_d;
    logic [31:0]  den_q, den_d;
    logic [15:0]  tmo_q, tmo_d;
    logic [GW-1:0] shadow_r_q, shadow_r_d, shadow_b_q, shadow_b_d;
    logic [GW-1:0] gain_r_q, gain_r_d, gain_b_q, gain_b_d;
    logic         upd_q, upd_d, overrun_q, overrun_d;
    logic         start_c, timeout_c, load_c;
    logic [19:0]  gain_c;

    // Saturate the Q4.16 quotient, then optionally clamp into the gain window.
    always_comb begin
        gain_c = (|quot_q[47:20]) ? 20'hFFFFF : quot_q[19:0];
        if (CLAMP_EN) begin
            if (gain_c < GAIN_MIN)      gain_c = GAIN_MIN;
            else if (gain_c > GAIN_MAX) gain_c = GAIN_MAX;
        end
    end

    always_comb begin
        state_d    = state_q;
        job_d      = job_q;
        snap_r_d   = snap_r_q;
        snap_g_d   = snap_g_q;
        snap_b_d   = snap_b_q;
        num_d      = num_q;
        den_d      = den_q;
        quot_d     = quot_q;
        tmo_d      = tmo_q;
        shadow_r_d = shadow_r_q;
        shadow_b_d = shadow_b_q;
        gain_r_d   = gain_r_q;
        gain_b_d   = gain_b_q;
        upd_d      = 1'b0;
        overrun_d  = 1'b0;
        start_c    = 1'b0;
        timeout_c  = 1'b0;
        load_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (I_frame_end) begin
                    snap_r_d = I_sum_r;
                    snap_g_d = I_sum_g;
                    snap_b_d = I_sum_b;
                    job_d    = 3'd0;
                    state_d  = S_ISSUE;
                    load_c   = 1'b1;
                end
            end
            S_ISSUE: begin
                tmo_d = 16'd0;
                if (den_q == 32'd0) begin
                    quot_d  = '1;
                    state_d = S_STORE;
                end else begin
                    start_c = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (div.I_div_done) begin
                    quot_d  = div.I_div_quot;
                    state_d = S_STORE;
                end else if (tmo_q == 16'(DIV_TIMEOUT - 1)) begin
                    timeout_c = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_STORE: begin
                if (job_q[0]) shadow_b_d[20*job_q[2:1] +: 20] = gain_c;
                else          shadow_r_d[20*job_q[2:1] +: 20] = gain_c;
                if (job_q == 3'd7) begin
                    state_d = S_PEND;
                end else begin
                    job_d   = job_q + 3'd1;
                    state_d = S_ISSUE;
                    load_c  = 1'b1;
                end
            end
            S_PEND: begin
                if (I_tuser) begin
                    gain_r_d = shadow_r_q;
                    gain_b_d = shadow_b_q;
                    upd_d    = 1'b1;
                    state_d  = S_IDLE;
                end
                // Newest stats win: a fresh snapshot replaces any uncommitted shadow.
                if (I_frame_end) begin
                    snap_r_d = I_sum_r;
                    snap_g_d = I_sum_g;
                    snap_b_d = I_sum_b;
                    job_d    = 3'd0;
                    state_d  = S_ISSUE;
                    load_c   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (I_frame_end && (state_q == S_ISSUE || state_q == S_WAIT || state_q == S_STORE))
            overrun_d = 1'b1;

        // Operands are latched on entry to ISSUE and stay put until the job leaves WAIT.
        if (load_c) begin
            num_d = {snap_g_d[32*job_d[2:1] +: 32], 16'd0};
            den_d = job_d[0] ? snap_b_d[32*job_d[2:1] +: 32] : snap_r_d[32*job_d[2:1] +: 32];
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q    <= S_IDLE;
            job_q      <= 3'd0;
            snap_r_q   <= '0;
            snap_g_q   <= '0;
            snap_b_q   <= '0;
            num_q      <= '0;
            den_q      <= '0;
            quot_q     <= '0;
            tmo_q      <= '0;
            shadow_r_q <= {LANES{20'h10000}};
            shadow_b_q <= {LANES{20'h10000}};
            gain_r_q   <= {LANES{20'h10000}};
            gain_b_q   <= {LANES{20'h10000}};
            upd_q      <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            job_q      <= job_d;
            snap_r_q   <= snap_r_d;
            snap_g_q   <= snap_g_d;
            snap_b_q   <= snap_b_d;
            num_q      <= num_d;
            den_q      <= den_d;
            quot_q     <= quot_d;
            tmo_q      <= tmo_d;
            shadow_r_q <= shadow_r_d;
            shadow_b_q <= shadow_b_d;
            gain_r_q   <= gain_r_d;
            gain_b_q   <= gain_b_d;
            upd_q      <= upd_d;
            overrun_q  <= overrun_d;
        end
    end

    assign div.O_div_start = start_c;
    assign div.O_div_num   = num_q;
    assign div.O_div_den   = den_q;
    assign O_gain_r        = gain_r_q;
    assign O_gain_b        = gain_b_q;
    assign O_gain_upd      = upd_q;
    assign O_busy          = (state_q != S_IDLE);
    assign O_overrun       = overrun_q;
    assign O_timeout       = timeout_c;
endmodule

// File: tb/tb_awb_gain_sched.sv
// Bench for awb_gain_sched: table-driven frames with a divider model, scoreboards
// for divider operands and committed gains, plus overrun/restart/timeout/reset sequences.
module tb_awb_gain_sched;
    localparam int LAT = 20;
    localparam int TMO = 128;

    logic         clk = 1'b0;
    logic         rst;
    logic         tuser, frame_end;
    logic [127:0] sum_r, sum_g, sum_b;
    logic [79:0]  gain_r, gain_b;
    logic         gain_upd, busy, overrun, timeout;

    awb_gain_sched_if div ();

    awb_gain_sched dut (
        .I_clk(clk), .I_rst(rst), .I_tuser(tuser), .I_frame_end(frame_end),
        .I_sum_r(sum_r), .I_sum_g(sum_g), .I_sum_b(sum_b), .div(div),
        .O_gain_r(gain_r), .O_gain_b(gain_b), .O_gain_upd(gain_upd),
        .O_busy(busy), .O_overrun(overrun), .O_timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int n_starts = 0, n_upd = 0, n_ovr = 0, n_tmo = 0, tmo_cyc = 0;
    int start_cyc [0:1023];
    logic [79:0]  exp_q [$];
    logic [159:0] gexp_q [$];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    always @(posedge clk) cyc++;

    // Divider model: done arrives LAT cycles after the start cycle; one start may hang.
    int mcount = 0, hang_abs = -1, dcnt = 0;
    logic dbusy = 1'b0;
    logic [47:0] dq;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dbusy = 1'b0;
            div.I_div_done = 1'b0;
            div.I_div_quot = '0;
        end else begin
            #1;
            div.I_div_done = 1'b0;
            if (dbusy) begin
                dcnt--;
                if (dcnt == 0) begin
                    div.I_div_done = 1'b1;
                    div.I_div_quot = dq;
                    dbusy = 1'b0;
                end
            end
            if (div.O_div_start) begin
                if (mcount != hang_abs) begin
                    dbusy = 1'b1;
                    dcnt  = LAT;
                    dq    = div.O_div_num / {16'd0, div.O_div_den};
                end
                mcount++;
            end
        end
    end

    // Output monitor: pops scoreboards when the DUT starts a division or commits.
    always @(negedge clk) begin
        if (!rst) begin
            if (div.O_div_start) begin
                start_cyc[n_starts] = cyc;
                n_starts++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL start_unexpected: got start num=%h den=%h want none", div.O_div_num, div.O_div_den);
                end else begin
                    check("div_operands", {div.O_div_num, div.O_div_den}, exp_q.pop_front());
                end
            end
            if (overrun) n_ovr++;
            if (timeout) begin
                n_tmo++;
                tmo_cyc = cyc;
            end
            if (gain_upd) begin
                n_upd++;
                $display("commit r=%h b=%h", gain_r, gain_b);
                if (gexp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL upd_unexpected: got commit want none");
                end else begin
                    check("committed_gains", {gain_r, gain_b}, gexp_q.pop_front());
                end
            end
        end
    end

    typedef struct {
        logic [127:0] r, g, b;
        logic [79:0]  er, eb;
        int           nstart;
    } vec_t;
    vec_t tbl [5];
    logic [79:0] prev_r, prev_b;

    function automatic logic [79:0] clampv(input logic [79:0] v);
        logic [79:0] o;
        o = v;
`ifdef AWB_GAIN_CLAMP_EN
        for (int k = 0; k < 4; k++) begin
            if (o[20*k +: 20] < 20'h04000)      o[20*k +: 20] = 20'h04000;
            else if (o[20*k +: 20] > 20'h40000) o[20*k +: 20] = 20'h40000;
        end
`endif
        return o;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_sums(input vec_t v);
        sum_r = v.r; sum_g = v.g; sum_b = v.b;
    endtask

    task automatic push_jobs(input vec_t v);
        logic [31:0] den;
        for (int j = 0; j < 8; j++) begin
            den = (j % 2 == 1) ? v.b[32*(j/2) +: 32] : v.r[32*(j/2) +: 32];
            if (den != 32'd0) exp_q.push_back({v.g[32*(j/2) +: 32], 16'd0, den});
        end
    endtask

    task automatic pulse_fe;
        frame_end = 1'b1; tick; frame_end = 1'b0;
    endtask

    task automatic commit(input vec_t v);
        gexp_q.push_back({clampv(v.er), clampv(v.eb)});
        tuser = 1'b1; tick; tuser = 1'b0;
        tick;
        prev_r = clampv(v.er);
        prev_b = clampv(v.eb);
    endtask

    task automatic wait_starts(input int target);
        for (int i = 0; i < 2000 && n_starts < target; i++) tick;
        check("start_wait", n_starts, target);
    endtask

    task automatic run_frame(input vec_t v);
        int s0, u0, o0;
        s0 = n_starts; u0 = n_upd; o0 = n_ovr;
        set_sums(v); push_jobs(v); pulse_fe;
        repeat (300) tick;
        check("pend_busy", busy, 1);
        check("shadow_hidden", {gain_r, gain_b}, {prev_r, prev_b});
        commit(v);
        check("start_count", n_starts - s0, v.nstart);
        check("upd_count", n_upd - u0, 1);
        check("idle_after_commit", busy, 0);
        check("no_overrun", n_ovr - o0, 0);
        if (v.nstart == 8) check("job_spacing", start_cyc[s0+7] - start_cyc[s0], 7 * (LAT + 2));
    endtask

    initial begin
        int s0, u0, o0;
        tbl[0] = '{{4{32'd1000}}, {4{32'd2000}}, {4{32'd4000}}, {4{20'h20000}}, {4{20'h08000}}, 8};
        tbl[1] = '{{32'd1000, 32'd0, 32'd1000, 32'd1000},
                   {32'h00100000, 32'd2000, 32'd2000, 32'd2000},
                   {32'd1, 32'd4000, 32'd4000, 32'd4000},
                   {20'hFFFFF, 20'hFFFFF, 20'h20000, 20'h20000},
                   {20'hFFFFF, 20'h08000, 20'h08000, 20'h08000}, 7};
        tbl[2] = '{{4{32'd1000}}, {4{32'd1000}}, {4{32'd1000}}, {4{20'h10000}}, {4{20'h10000}}, 8};
        tbl[3] = '{{4{32'd3}}, {4{32'd1}}, {4{32'd7}}, {4{20'h05555}}, {4{20'h02492}}, 8};
        tbl[4] = '{{4{32'd2000000}}, {4{32'd1000}}, {4{32'd1000}}, {4{20'h00020}}, {4{20'h10000}}, 8};

        rst = 1'b1; tuser = 1'b0; frame_end = 1'b0;
        sum_r = '0; sum_g = '0; sum_b = '0;
        prev_r = {4{20'h10000}}; prev_b = {4{20'h10000}};
        repeat (3) tick;
        check("rst_gain_r", gain_r, {4{20'h10000}});
        check("rst_gain_b", gain_b, {4{20'h10000}});
        check("rst_div_num_den", {div.O_div_num, div.O_div_den}, 80'd0);
        check("rst_pulses", {div.O_div_start, gain_upd, overrun, timeout, busy}, 5'd0);
        rst = 1'b0;
        tick;

        // Divider hangs on job 5: abort after the timeout, active gains untouched.
        hang_abs = mcount + 5;
        s0 = n_starts; u0 = n_upd;
        set_sums(tbl[0]); push_jobs(tbl[0]); pulse_fe;
        for (int i = 0; i < 2000 && n_tmo == 0; i++) tick;
        check("timeout_seen", n_tmo, 1);
        check("timeout_delay", tmo_cyc - start_cyc[s0+5], TMO);
        check("timeout_jobs_left", exp_q.size(), 2);
        exp_q.delete();
        tick;
        check("timeout_idle", busy, 0);
        check("timeout_gains", {gain_r, gain_b}, {{4{20'h10000}}, {4{20'h10000}}});
        check("timeout_no_upd", n_upd - u0, 0);
        hang_abs = -1;

        for (int t = 0; t < 5; t++) run_frame(tbl[t]);

        // Overrun: second frame_end during WAIT of job 3 with different live sums.
        s0 = n_starts; o0 = n_ovr;
        set_sums(tbl[2]); push_jobs(tbl[2]); pulse_fe;
        wait_starts(s0 + 4);
        repeat (3) tick;
        set_sums(tbl[0]); pulse_fe;
        repeat (300) tick;
        check("overrun_count", n_ovr - o0, 1);
        check("overrun_starts", n_starts - s0, 8);
        commit(tbl[2]);

        // Restart in PEND: first shadow must never be published.
        s0 = n_starts; u0 = n_upd; o0 = n_ovr;
        set_sums(tbl[3]); push_jobs(tbl[3]); pulse_fe;
        repeat (300) tick;
        set_sums(tbl[4]); push_jobs(tbl[4]); pulse_fe;
        check("restart_no_overrun", n_ovr - o0, 0);
        repeat (300) tick;
        check("restart_no_upd", n_upd - u0, 0);
        check("restart_active_kept", {gain_r, gain_b}, {prev_r, prev_b});
        commit(tbl[4]);
        check("restart_upd_once", n_upd - u0, 1);
        check("restart_starts", n_starts - s0, 16);

        // Asynchronous reset between clock edges during WAIT of job 4.
        s0 = n_starts;
        set_sums(tbl[0]); push_jobs(tbl[0]); pulse_fe;
        wait_starts(s0 + 5);
        repeat (3) tick;
        #3;
        rst = 1'b1;
        #1;
        check("arst_gain_r", gain_r, {4{20'h10000}});
        check("arst_gain_b", gain_b, {4{20'h10000}});
        check("arst_div_num_den", {div.O_div_num, div.O_div_den}, 80'd0);
        check("arst_busy_start", {busy, div.O_div_start}, 2'd0);
        exp_q.delete();
        prev_r = {4{20'h10000}}; prev_b = {4{20'h10000}};
        @(posedge clk); #1;
        rst = 1'b0;
        tick;
        run_frame(tbl[0]);

        check("ops_queue_empty", exp_q.size(), 0);
        check("gain_queue_empty", gexp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/awb_gain_sched.md
Name: awb_gain_sched

Overview:
- Per-frame gain scheduler for the AWB stage.
- At end of frame it snapshots the four-lane R/G/B channel sums and time-shares ONE external divider across the 8 gain divisions (G/R and G/B for lanes 0..3).
- Quotients are saturated to 20-bit Q4.16 gains in a shadow bank. The bank is published atomically at the next frame start, so the pixel multiplier never sees a half-updated gain set.

Parameters:
- LANES, 4, pixel lanes per beat (fixed at 4; ports sized for 4).
- DIV_TIMEOUT, 128, max cycles waiting for div_done before aborting the update.
- GAIN_MIN, 20'h04000, lower gain clamp (0.25); used only with AWB_GAIN_CLAMP_EN.
- GAIN_MAX, 20'h40000, upper gain clamp (4.0); used only with AWB_GAIN_CLAMP_EN.

Ports:
- I_clk  in  1  clock.
- I_rst  in  1  asynchronous reset, active-high.
- I_tuser  in  1  frame-start pulse (one cycle); commit point.
- I_frame_end  in  1  stats-complete pulse (one cycle).
- I_sum_r  in  128  lane sums, lane k at [32k+:32].
- I_sum_g  in  128  lane sums, lane k at [32k+:32].
- I_sum_b  in  128  lane sums, lane k at [32k+:32].
- O_div_start  out  1  one-cycle divider start.
- O_div_num  out  48  dividend = {sum_g[k],16'd0}.
- O_div_den  out  32  divisor = sum_r[k] or sum_b[k].
- I_div_quot  in  48  divider quotient.
- I_div_done  in  1  quotient valid pulse.
- O_gain_r  out  80  active R gains, lane k at [20k+:20].
- O_gain_b  out  80  active B gains, lane k at [20k+:20].
- O_gain_upd  out  1  one-cycle pulse on the cycle after a commit.
- O_busy  out  1  high in any state except IDLE.
- O_overrun  out  1  one-cycle pulse when I_frame_end is dropped.
- O_timeout  out  1  one-cycle pulse when a divider wait aborts.

Behaviour:
Reset:
- All gains (active and shadow) = 20'h10000.
- All pulse outputs = 0, O_div_num/O_div_den = 0, state = IDLE, job index = 0.

States:
- IDLE, ISSUE, WAIT, STORE, PEND.

Job order:
- Job j = 0..7, lane = j>>1, even j = R (den = sum_r), odd j = B (den = sum_b).

Transitions:
- IDLE: on I_frame_end, snapshot all 12 sums into internal registers, set j = 0, go to ISSUE. The divider uses only the snapshot, never the live sums.
- ISSUE: drive O_num/O_den from the snapshot and pulse O_div_start for one cycle. Clear the timeout counter. Go to WAIT.
- ISSUE, zero divisor: if den == 0, do NOT pulse start; force the quotient to saturate and go directly to STORE.
- WAIT: on I_div_done, register I_div_quot and go to STORE.
- WAIT timeout: if the counter reaches DIV_TIMEOUT-1 without done, pulse O_timeout, discard the shadow bank (active gains unchanged) and go to IDLE.
- STORE: gain = (|quot[47:20]) ? 20'hFFFFF : quot[19:0], written to shadow[j]. If j == 7 go to PEND, else j++ and go to ISSUE.
- PEND: on I_tuser, copy shadow to active and go to IDLE. O_gain_upd pulses the next cycle.

Dropped and restarted snapshots:
- I_frame_end in ISSUE/WAIT/STORE: ignored, O_overrun pulses; the in-flight update completes.
- I_frame_end in PEND without I_tuser: the pending shadow is discarded, a new snapshot is taken and the block goes to ISSUE with j = 0 (newest stats win). No overrun pulse.
- I_tuser and I_frame_end in the same PEND cycle: commit AND a new snapshot in that cycle, then go to ISSUE.
- I_tuser outside PEND: no effect.

Divider handshake:
- A stray I_div_done outside WAIT is ignored.
- At most one division is outstanding.
- O_div_num/O_div_den are held stable from ISSUE until leaving WAIT.

Latency:
- Per job: 1 (ISSUE) + Ldiv + 1 (STORE).
- Total from I_frame_end to PEND: 1 + 8*(Ldiv+2) cycles.
- Commit is visible on O_gain_* the cycle after I_tuser.

Reset mid-operation:
- Immediately returns to the reset state; any partial shadow bank is lost.

Optional Feature:
- Macro: AWB_GAIN_CLAMP_EN.
- Defined: after saturation, STORE clamps each gain to [GAIN_MIN, GAIN_MAX]; a zero-divisor job stores GAIN_MAX.
- Undefined: only the 20'hFFFFF saturation applies, and GAIN_MIN/GAIN_MAX are unused.

Test Plan:
- Nominal update: sums r = 1000, g = 2000, b = 4000 on all lanes, divider model latency 20, I_frame_end then I_tuser 300 cycles later. Required: 8 start pulses in job order; after commit, every R gain = 20'h20000 and every B gain = 20'h08000; O_gain_upd pulses once; O_busy is low after commit.
- Zero and overflow: lane 2 sum_r = 0, lane 3 sum_b = 1 with sum_g = 2^20. Required: only 7 start pulses; lane 2 R gain = 20'hFFFFF and lane 3 B gain = 20'hFFFFF (clamp off), or both = GAIN_MAX (clamp on).
- Overrun: second I_frame_end while in WAIT of job 3. Required: O_overrun pulses once; the update finishes with the first snapshot's values.
- Restart in PEND: new I_frame_end in PEND with different sums and no I_tuser. Required: the first shadow is never published; after the next I_tuser, active gains equal the second snapshot.
- Timeout: divider never asserts done at job 5. Required: O_timeout pulses exactly DIV_TIMEOUT cycles after that start; active gains are unchanged at 20'h10000; state returns to IDLE.
- Async reset: assert I_rst during WAIT of job 4 with no clock edge. Required: outputs immediately at reset values; a following full frame updates normally.
